// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and the
// default sizing constants used by the top level.
package fifo_ctrl_pkg;

  // Arbiter FSM: IDLE arbitrates, GRANT owns the FIFO write port.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Default sizing.
  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  // Width of a beat counter that must be able to hold max_burst itself.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: starting one position after last_id and wrapping,
// returns the first requester whose request bit is set.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_id_i,
  output logic [IDW-1:0]  pick_o,
  output logic            found_o
);

  // Scan offsets from farthest to nearest so the nearest hit after last_id
  // is the one left standing; offset NREQ is last_id itself (lowest priority).
  always_comb begin
    pick_o  = {IDW{1'b0}};
    found_o = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      logic [IDW-1:0] idx;
      idx     = IDW'((int'(last_id_i) + off) % NREQ);
      pick_o  = req_i[idx] ? idx : pick_o;
      found_o = found_o | req_i[idx];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for an asynchronous FIFO. Several requesters compete for
// the single write port; the winner keeps the port until its packet ends, it
// reaches MAX_BURST accepted beats, or it goes idle. A full FIFO only stalls
// the owner, it never takes the grant away.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     wr_clk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic                     grant_active,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = beat_cnt_width(MAX_BURST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  arb_state_e      state_q,    state_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  last_id_q,  last_id_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            valid_sel_s;
  logic            last_sel_s;
  logic [CW-1:0]   beat_inc_s;
  logic [IDW-1:0]  pick_id_s;
  logic            pick_found_s;

  // Round-robin pick among all valid requesters, priority starting after last_id.
  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i     (req_valid),
    .last_id_i (last_id_q),
    .pick_o    (pick_id_s),
    .found_o   (pick_found_s)
  );

  // Select the owner's valid, last and data lanes with an AND-OR mux.
  always_comb begin
    valid_sel_s  = 1'b0;
    last_sel_s   = 1'b0;
    fifo_wr_data = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      logic hit;
      hit          = (grant_id_q == IDW'(i));
      valid_sel_s  = valid_sel_s | (hit & req_valid[i]);
      last_sel_s   = last_sel_s  | (hit & req_last[i]);
      fifo_wr_data = fifo_wr_data | ({WIDTH{hit}} & req_data[i*WIDTH +: WIDTH]);
    end
  end

  // Ready goes only to the owner and only while the FIFO can take a beat;
  // it does not depend on the owner's valid so there is no valid/ready loop.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_active & ~fifo_full & (grant_id_q == IDW'(i));
    end
  end

  assign grant_active = (state_q == GRANT);
  assign fifo_wr_en   = grant_active & valid_sel_s & ~fifo_full;
  assign grant_id     = grant_id_q;

  // Next-state logic: arbitrate in IDLE, count accepted beats and decide
  // release in GRANT. Last and max-burst on the same beat is one release.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    beat_inc_s = beat_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d    = GRANT;
          grant_id_d = pick_id_s;
          last_id_d  = pick_id_s;
          beat_cnt_d = {CW{1'b0}};
        end else begin
          state_d    = IDLE;
        end
      end
      GRANT: begin
        if (fifo_wr_en) begin
          beat_cnt_d = beat_inc_s;
          if (last_sel_s || (beat_inc_s == MAX_CNT)) begin
            state_d = IDLE;
          end else begin
            state_d = GRANT;
          end
        end else if (!valid_sel_s && !fifo_full) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= {IDW{1'b0}};
      last_id_q  <= IDW'(NREQ - 1);
      beat_cnt_q <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Each cycle the observed vector {grant_active, grant_id, fifo_wr_en,
// req_ready, fifo_wr_data} is compared against a hand-derived expectation.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        wrst_n = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_last  = 4'b0000;
  logic [31:0] req_data  = 32'h0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        grant_active;
  logic [1:0]  grant_id;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] obs;
  assign obs = {grant_active, grant_id, fifo_wr_en, req_ready, fifo_wr_data};

  fifo_wr_arbiter #(
    .NREQ      (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .wr_clk       (wr_clk),
    .wrst_n       (wrst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [15:0] vec(input logic ga, input logic [1:0] gid,
                                      input logic we, input logic [3:0] rdy,
                                      input logic [7:0] d);
    return {ga, gid, we, rdy, d};
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n    = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0;
    fifo_full = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'h44332211;
    tick();
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'h11);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp);
    end
    req_valid = 4'b0000;
    wrst_n    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'h11);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL idle_no_req c%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] exp;
    logic [7:0]  d;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h000000A0;
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'hA0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL single_arb: got %h expected %h", obs, exp);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      d = 8'hA0 + 8'(b);
      req_data[7:0] = d;
      req_last      = (b == 2) ? 4'b0001 : 4'b0000;
      #1;
      exp = vec(1'b1, 2'd0, 1'b1, 4'b0001, d);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL single_beat%0d: got %h expected %h", b, obs, exp);
      end
    end
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'hA2);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL single_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp;
    logic [1:0]  gid;
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hB3B2B1B0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      if (c % 2 == 1) begin
        gid = 2'(((c - 1) / 2) % 4);
        exp = vec(1'b1, gid, 1'b1, 4'b0001 << gid, 8'hB0 + 8'(gid));
      end else begin
        gid = (c == 0) ? 2'd0 : 2'(((c - 2) / 2) % 4);
        exp = vec(1'b0, gid, 1'b0, 4'b0000, 8'hB0 + 8'(gid));
      end
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL round_robin c%0d: got %h expected %h", c, obs, exp);
      end
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tick();
  endtask

  task automatic test_max_burst();
    logic [15:0] exp;
    logic [14:0] act_pat;
    logic [14:0] we_pat;
    logic [1:0]  gid;
    logic [7:0]  d;
    int          n;
    act_pat = 15'b011101111011110;
    we_pat  = 15'b001101111011110;
    n = 0;
    do_reset();
    req_last = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      req_valid = (n < 10) ? 4'b0100 : 4'b0000;
      d = 8'hC0 + 8'(n);
      req_data[23:16] = d;
      #1;
      gid = (c == 0) ? 2'd0 : 2'd2;
      exp = vec(act_pat[c], gid, we_pat[c], act_pat[c] ? 4'b0100 : 4'b0000,
                (gid == 2'd2) ? d : 8'h00);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL max_burst c%0d: got %h expected %h", c, obs, exp);
      end
      if (we_pat[c]) n++;
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] exp;
    logic [10:0] act_pat;
    logic [10:0] we_pat;
    logic [7:0]  d;
    logic        rdy;
    int          n;
    act_pat = 11'b01111111110;
    we_pat  = 11'b01100000110;
    n = 0;
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      fifo_full = (c >= 3) && (c <= 7);
      d = 8'hD0 + 8'(n);
      req_data[7:0] = d;
      #1;
      rdy = act_pat[c] & ~fifo_full;
      exp = vec(act_pat[c], 2'd0, we_pat[c], {3'b000, rdy}, d);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL full_stall c%0d: got %h expected %h", c, obs, exp);
      end
      if (we_pat[c]) n++;
    end
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] exp;
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000E100;
    #1;
    for (int c = 1; c < 3; c++) begin
      tick();
      #1;
      exp = vec(1'b1, 2'd1, 1'b1, 4'b0010, 8'hE1);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL pre_reset_beat%0d: got %h expected %h", c, obs, exp);
      end
    end
    #1;
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL async_abort: got %h expected %h", obs, exp);
    end
    tick();
    wrst_n = 1'b1;
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, exp);
    end
    tick();
    #1;
    exp = vec(1'b1, 2'd0, 1'b1, 4'b0001, 8'h00);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL post_reset_prio: got %h expected %h", obs, exp);
    end
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_valid_drop();
    logic [15:0] exp;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'hF3F2F1F0;
    #1;
    tick();
    #1;
    exp = vec(1'b1, 2'd0, 1'b1, 4'b0001, 8'hF0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL drop_beat: got %h expected %h", obs, exp);
    end
    tick();
    req_valid = 4'b1000;
    #1;
    exp = vec(1'b1, 2'd0, 1'b0, 4'b0001, 8'hF0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL drop_idle_owner: got %h expected %h", obs, exp);
    end
    tick();
    #1;
    exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'hF0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL drop_release: got %h expected %h", obs, exp);
    end
    tick();
    #1;
    exp = vec(1'b1, 2'd3, 1'b1, 4'b1000, 8'hF3);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL drop_next_grant: got %h expected %h", obs, exp);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_last_at_max();
    logic [15:0] exp;
    logic [7:0]  d;
    do_reset();
    req_valid = 4'b0001;
    #1;
    for (int b = 0; b < 4; b++) begin
      tick();
      d = 8'h50 + 8'(b);
      req_data[7:0] = d;
      req_last      = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      exp = vec(1'b1, 2'd0, 1'b1, 4'b0001, d);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL coincide_beat%0d: got %h expected %h", b, obs, exp);
      end
    end
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      #1;
      exp = vec(1'b0, 2'd0, 1'b0, 4'b0000, 8'h53);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL coincide_release c%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_reset_mid_burst();
    test_valid_drop();
    test_last_at_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
